// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - opcode constants and FSM state encoding shared by the arithmetic unit
package arith_pkg;

  localparam logic [1:0] OP_DIV = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/arith_iter_step.sv
// rtl/arith_iter_step.sv - one shift-add multiply or restoring-divide iteration
// work holds {hi, lo}: multiply {partial product, remaining multiplier}, divide {remainder, dividend/quotient}.
module arith_iter_step
  import arith_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [1:0]     op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [2*W-1:0] work_in,
  output logic [2*W-1:0] work_out
);

  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [W:0]   mul_sum;
  logic [W-1:0] addend;
  logic [W:0]   div_shift;
  logic         div_ge;
  logic [W-1:0] div_rem;

  assign hi = work_in[2*W-1:W];
  assign lo = work_in[W-1:0];

  // Multiply consumes the multiplier LSB-first; the carry falls into the shifted-down word.
  assign addend  = lo[0] ? a : '0;
  assign mul_sum = {1'b0, hi} + {1'b0, addend};

  // Remainder after a successful subtract is below b, so W-bit modular subtraction is exact.
  assign div_shift = {hi, lo[W-1]};
  assign div_ge    = (div_shift >= {1'b0, b});
  assign div_rem   = div_ge ? (div_shift[W-1:0] - b) : div_shift[W-1:0];

  always_comb begin
    work_out = work_in;
    if (op == OP_MUL) begin
      work_out = {mul_sum, lo[W-1:1]};
    end else begin
      work_out = {div_rem, lo[W-2:0], div_ge};
    end
  end

endmodule

// File: rtl/arith_seq_unit.sv
// rtl/arith_seq_unit.sv - sequential add / abs-subtract / multiply / divide unit
// Add, subtract and divide-by-zero finish on the accepting edge; multiply and divide iterate W cycles.
module arith_seq_unit
  import arith_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable_low,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] y,
  output logic           sign,
  output logic           div_zero,
  output logic           busy,
  output logic           done
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  state_t         state_q, state_d;
  logic [1:0]     op_q, op_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [2*W-1:0] work_q, work_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] y_q, y_d;
  logic           sign_q, sign_d;
  logic           div_zero_q, div_zero_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [2*W-1:0] step_work;
  logic [W:0]     add_sum;
  logic [W-1:0]   sub_diff;
  logic           sub_neg;

  arith_iter_step #(.W(W)) u_step (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .work_in  (work_q),
    .work_out (step_work)
  );

  assign add_sum  = {1'b0, a} + {1'b0, b};
  assign sub_neg  = (b > a);
  assign sub_diff = sub_neg ? (b - a) : (a - b);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    work_d     = work_q;
    cnt_d      = cnt_q;
    y_d        = y_q;
    sign_d     = sign_q;
    div_zero_d = div_zero_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    if (enable_low) begin
      // Abort clears results but never signals completion.
      state_d    = ST_IDLE;
      cnt_d      = '0;
      y_d        = '0;
      sign_d     = 1'b0;
      div_zero_d = 1'b0;
      busy_d     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_d       = op;
            a_d        = a;
            b_d        = b;
            cnt_d      = '0;
            sign_d     = 1'b0;
            div_zero_d = 1'b0;
            busy_d     = 1'b1;
            case (op)
              OP_ADD: begin
                y_d     = {{(W-1){1'b0}}, add_sum};
                state_d = ST_DONE;
                done_d  = 1'b1;
              end
              OP_SUB: begin
                y_d     = {{W{1'b0}}, sub_diff};
                sign_d  = sub_neg;
                state_d = ST_DONE;
                done_d  = 1'b1;
              end
              OP_MUL: begin
                work_d  = {{W{1'b0}}, b};
                state_d = ST_CALC;
              end
              default: begin
                if (b == '0) begin
                  y_d        = '1;
                  div_zero_d = 1'b1;
                  state_d    = ST_DONE;
                  done_d     = 1'b1;
                end else begin
                  work_d  = {{W{1'b0}}, a};
                  state_d = ST_CALC;
                end
              end
            endcase
          end
        end
        ST_CALC: begin
          work_d = step_work;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            y_d     = step_work;
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_DIV;
      a_q        <= '0;
      b_q        <= '0;
      work_q     <= '0;
      cnt_q      <= '0;
      y_q        <= '0;
      sign_q     <= 1'b0;
      div_zero_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      work_q     <= work_d;
      cnt_q      <= cnt_d;
      y_q        <= y_d;
      sign_q     <= sign_d;
      div_zero_q <= div_zero_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign y        = y_q;
  assign sign     = sign_q;
  assign div_zero = div_zero_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_arith_seq_unit.sv
// tb/tb_arith_seq_unit.sv - directed self-checking bench for arith_seq_unit (W=8)
module tb_arith_seq_unit;

  logic        clk;
  logic        rst_n;
  logic        enable_low;
  logic        start;
  logic [1:0]  op;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] y;
  logic        sign;
  logic        div_zero;
  logic        busy;
  logic        done;

  int tests_run;
  int tests_failed;

  arith_seq_unit #(.W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable_low (enable_low),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .y          (y),
    .sign       (sign),
    .div_zero   (div_zero),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic issue(input logic [1:0] o, input logic [7:0] ia, input logic [7:0] ib, output int lat);
    @(negedge clk);
    op = o; a = ia; b = ib; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    #3;
    tests_run++;
    if (y !== 16'd0 || sign !== 1'b0 || div_zero !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got y=%0h sign=%0b dz=%0b, want 0/0/0", y, sign, div_zero);
    end
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got busy=%0b done=%0b, want 0/0", busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add;
    int lat;
    issue(2'b01, 8'd200, 8'd100, lat);
    tests_run++;
    if (lat != 1 || y !== 16'd300 || sign !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL add_200_100: got lat=%0d y=%0d sign=%0b busy=%0b, want 1/300/0/1", lat, y, sign, busy);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0 || y !== 16'd300) begin
      tests_failed++;
      $display("FAIL add_hold: got done=%0b busy=%0b y=%0d, want 0/0/300", done, busy, y);
    end
    issue(2'b01, 8'd255, 8'd255, lat);
    tests_run++;
    if (lat != 1 || y !== 16'd510) begin
      tests_failed++;
      $display("FAIL add_carry: got lat=%0d y=%0d, want 1/510", lat, y);
    end
  endtask

  task automatic test_sub;
    int lat;
    issue(2'b10, 8'd5, 8'd9, lat);
    tests_run++;
    if (lat != 1 || y !== 16'd4 || sign !== 1'b1) begin
      tests_failed++;
      $display("FAIL sub_5_9: got lat=%0d y=%0d sign=%0b, want 1/4/1", lat, y, sign);
    end
    issue(2'b10, 8'd9, 8'd5, lat);
    tests_run++;
    if (lat != 1 || y !== 16'd4 || sign !== 1'b0) begin
      tests_failed++;
      $display("FAIL sub_9_5: got lat=%0d y=%0d sign=%0b, want 1/4/0", lat, y, sign);
    end
    issue(2'b10, 8'd7, 8'd7, lat);
    tests_run++;
    if (y !== 16'd0 || sign !== 1'b0) begin
      tests_failed++;
      $display("FAIL sub_equal: got y=%0d sign=%0b, want 0/0", y, sign);
    end
  endtask

  task automatic test_mul_div;
    int lat;
    @(negedge clk);
    op = 2'b11; a = 8'd255; b = 8'd255; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    @(negedge clk); lat++;
    @(negedge clk); lat++;
    // A stray request mid-CALC must not disturb the latched operands.
    op = 2'b01; a = 8'd1; b = 8'd1; start = 1'b1;
    @(negedge clk); lat++;
    start = 1'b0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    tests_run++;
    if (lat != 9 || y !== 16'd65025) begin
      tests_failed++;
      $display("FAIL mul_255_255: got lat=%0d y=%0d, want 9/65025", lat, y);
    end
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || y !== 16'd65025) begin
      tests_failed++;
      $display("FAIL mul_after: got busy=%0b done=%0b y=%0d, want 0/0/65025", busy, done, y);
    end
    issue(2'b00, 8'd100, 8'd7, lat);
    tests_run++;
    if (lat != 9 || y !== 16'h020E || div_zero !== 1'b0) begin
      tests_failed++;
      $display("FAIL div_100_7: got lat=%0d y=%0h dz=%0b, want 9/20e/0", lat, y, div_zero);
    end
    issue(2'b11, 8'd13, 8'd11, lat);
    tests_run++;
    if (lat != 9 || y !== 16'd143) begin
      tests_failed++;
      $display("FAIL mul_13_11: got lat=%0d y=%0d, want 9/143", lat, y);
    end
    issue(2'b00, 8'd255, 8'd16, lat);
    tests_run++;
    if (lat != 9 || y !== 16'h0F0F) begin
      tests_failed++;
      $display("FAIL div_255_16: got lat=%0d y=%0h, want 9/f0f", lat, y);
    end
  endtask

  task automatic test_div_zero;
    int lat;
    issue(2'b00, 8'd42, 8'd0, lat);
    tests_run++;
    if (lat != 1 || y !== 16'hFFFF || div_zero !== 1'b1) begin
      tests_failed++;
      $display("FAIL div_zero: got lat=%0d y=%0h dz=%0b, want 1/ffff/1", lat, y, div_zero);
    end
    issue(2'b01, 8'd1, 8'd1, lat);
    tests_run++;
    if (y !== 16'd2 || div_zero !== 1'b0) begin
      tests_failed++;
      $display("FAIL div_zero_clear: got y=%0d dz=%0b, want 2/0", y, div_zero);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    issue(2'b01, 8'd10, 8'd20, lat);
    op = 2'b01; a = 8'd3; b = 8'd4; start = 1'b1;
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0 || y !== 16'd30) begin
      tests_failed++;
      $display("FAIL b2b_in_done: got done=%0b busy=%0b y=%0d, want 0/0/30", done, busy, y);
    end
    @(negedge clk);
    start = 1'b0;
    tests_run++;
    if (done !== 1'b1 || y !== 16'd7) begin
      tests_failed++;
      $display("FAIL b2b_accept: got done=%0b y=%0d, want 1/7", done, y);
    end
  endtask

  task automatic test_abort_reset;
    int dones;
    @(negedge clk);
    op = 2'b11; a = 8'd255; b = 8'd255; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (y !== 16'd0 || busy !== 1'b0 || done !== 1'b0 || sign !== 1'b0 || div_zero !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_calc: got y=%0h busy=%0b done=%0b, want 0/0/0", y, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    tests_run++;
    if (dones != 0) begin
      tests_failed++;
      $display("FAIL reset_no_done: got %0d active cycles, want 0", dones);
    end
    // First start lands on the first edge after reset release.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    op = 2'b01; a = 8'd6; b = 8'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests_run++;
    if (done !== 1'b1 || y !== 16'd14) begin
      tests_failed++;
      $display("FAIL first_start: got done=%0b y=%0d, want 1/14", done, y);
    end
  endtask

  task automatic test_abort_enable;
    int dones;
    @(negedge clk);
    op = 2'b00; a = 8'd100; b = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    enable_low = 1'b1;
    @(negedge clk);
    enable_low = 1'b0;
    tests_run++;
    if (y !== 16'd0 || busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL enable_abort: got y=%0h busy=%0b done=%0b, want 0/0/0", y, busy, done);
    end
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    tests_run++;
    if (dones != 0) begin
      tests_failed++;
      $display("FAIL enable_no_done: got %0d done pulses, want 0", dones);
    end
    enable_low = 1'b1;
    op = 2'b01; a = 8'd2; b = 8'd3; start = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || y !== 16'd0) begin
      tests_failed++;
      $display("FAIL enable_blocks_start: got busy=%0b done=%0b y=%0d, want 0/0/0", busy, done, y);
    end
    start = 1'b0;
    enable_low = 1'b0;
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    enable_low = 1'b0;
    start = 1'b0;
    op = 2'b00;
    a = 8'd0;
    b = 8'd0;
    test_reset();
    test_add();
    test_sub();
    test_mul_div();
    test_div_zero();
    test_back_to_back();
    test_abort_reset();
    test_abort_enable();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
